// File: rtl/spi_sel_pkg.sv
// Shared constants for the MISO slave-select path: channel count, debounce default,
// commit FSM states and the one-hot select codes.
package spi_sel_pkg;

  localparam int N_CH             = 7;
  localparam int DEBOUNCE_DEFAULT = 1000000;  // 20 ms at 50 MHz

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [N_CH-1:0] SEL_NONE = 7'b0000000;
  localparam logic [N_CH-1:0] SEL_1    = 7'b0000001;
  localparam logic [N_CH-1:0] SEL_2    = 7'b0000010;
  localparam logic [N_CH-1:0] SEL_3    = 7'b0000100;
  localparam logic [N_CH-1:0] SEL_4    = 7'b0001000;
  localparam logic [N_CH-1:0] SEL_5    = 7'b0010000;
  localparam logic [N_CH-1:0] SEL_6    = 7'b0100000;
  localparam logic [N_CH-1:0] SEL_7    = 7'b1000000;

  function automatic logic [N_CH-1:0] sel_code(input int idx);
    case (idx)
      0:       sel_code = SEL_1;
      1:       sel_code = SEL_2;
      2:       sel_code = SEL_3;
      3:       sel_code = SEL_4;
      4:       sel_code = SEL_5;
      5:       sel_code = SEL_6;
      6:       sel_code = SEL_7;
      default: sel_code = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-FF synchroniser, polarity normalisation, stability counter
// and a one-cycle press pulse on each accepted released-to-pressed transition.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit SW_ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_key,
  output logic press
);

  localparam int               CNT_W        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RAW_RELEASED = SW_ACTIVE_LOW;

  logic             sync_p0, sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             stable_p2, stable_d, press_p3;

  // Internally 1 means pressed regardless of board wiring.
  assign level = sync_p1 ^ RAW_RELEASED;
  assign press = press_p3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0   <= RAW_RELEASED;
      sync_p1   <= RAW_RELEASED;
      cnt       <= '0;
      stable_p2 <= 1'b0;
      stable_d  <= 1'b0;
      press_p3  <= 1'b0;
    end else begin
      // p0/p1: synchroniser
      sync_p0 <= sw_key;
      sync_p1 <= sync_p0;
      // p2: level must differ from stable for DEBOUNCE_CYCLES straight cycles
      if (level == stable_p2) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable_p2 <= level;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // p3: rising edge of stable; releases are not events
      stable_d <= stable_p2;
      press_p3 <= stable_p2 & ~stable_d;
    end
  end

endmodule

// File: rtl/sw_sel_debounce.sv
// Front-panel slave-select: seven debounced keys feed a toggle/priority pending
// selection that is committed to the MISO flags only while the MCU SPI bus is idle.
module sw_sel_debounce
  import spi_sel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter bit SW_ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_key1,
  input  logic sw_key2,
  input  logic sw_key3,
  input  logic sw_key4,
  input  logic sw_key5,
  input  logic sw_key6,
  input  logic sw_key7,
  input  logic mcu_spi_cs_n,
  output logic sw_flag1,
  output logic sw_flag2,
  output logic sw_flag3,
  output logic sw_flag4,
  output logic sw_flag5,
  output logic sw_flag6,
  output logic sw_flag7,
  output logic sel_change
);

  logic [N_CH-1:0] keys, press;
  logic [N_CH-1:0] sel_p, pending, pending_nxt, flags, flags_nxt;
  logic            cs_sync_p0, cs_sync_p1, sel_change_nxt;
  state_t          state, state_nxt;

  assign keys = {sw_key7, sw_key6, sw_key5, sw_key4, sw_key3, sw_key2, sw_key1};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SW_ACTIVE_LOW  (SW_ACTIVE_LOW)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .sw_key(keys[i]),
      .press (press[i])
    );
  end

  // Lowest index wins among simultaneous presses; pressing the pending key clears it.
  always_comb begin
    sel_p = SEL_NONE;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press[i]) sel_p = sel_code(i);
    end
    pending_nxt = pending;
    if (sel_p != SEL_NONE) pending_nxt = (sel_p == pending) ? SEL_NONE : sel_p;
  end

  // The cycle that sees cs_n high again is already the first idle cycle, so it may commit.
  always_comb begin
    state_nxt      = state;
    flags_nxt      = flags;
    sel_change_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_sync_p1) begin
          state_nxt = BUSY;
        end else if (pending != flags) begin
          flags_nxt      = pending;
          sel_change_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (cs_sync_p1) begin
          state_nxt = IDLE;
          if (pending != flags) begin
            flags_nxt      = pending;
            sel_change_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_p0 <= 1'b1;
      cs_sync_p1 <= 1'b1;
      pending    <= SEL_NONE;
      state      <= IDLE;
      flags      <= SEL_NONE;
      sel_change <= 1'b0;
    end else begin
      cs_sync_p0 <= mcu_spi_cs_n;
      cs_sync_p1 <= cs_sync_p0;
      pending    <= pending_nxt;
      state      <= state_nxt;
      flags      <= flags_nxt;
      sel_change <= sel_change_nxt;
    end
  end

  assign {sw_flag7, sw_flag6, sw_flag5, sw_flag4, sw_flag3, sw_flag2, sw_flag1} = flags;

endmodule

// File: doc/sw_sel_debounce.md
# sw_sel_debounce

Upstream selection stage for the MISO return mux. It turns seven raw front-panel slave-select switches into the debounced, strictly one-hot (or all-zero) `sw_flag1`..`sw_flag7` vector that drives MISO routing. It commits a new selection only while the MCU SPI bus is idle (`mcu_spi_cs_n` high), so MISO never re-routes mid-frame.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles needed to accept a switch level. Must be at least 2. The default is 20 ms at 50 MHz.
- `SW_ACTIVE_LOW`, default 1: when 1, a raw key reads 0 when pressed.

Ports:
- `clk` input 1: single system clock.
- `rst` input 1: asynchronous, active-high reset.
- `sw_key1`..`sw_key7` input 1 each: raw, asynchronous switch inputs.
- `mcu_spi_cs_n` input 1: MCU SPI chip select, asynchronous, low means a frame is in progress.
- `sw_flag1`..`sw_flag7` output 1 each: committed selection, one-hot or all zero.
- `sel_change` output 1: one-cycle pulse when the committed selection changes.

## Operation
- **Synchronisers.** Every `sw_key*` and `mcu_spi_cs_n` passes through a 2-FF synchroniser. No logic samples a raw input.
- **Polarity.** The pressed level is normalised using `SW_ACTIVE_LOW`. Internally, 1 means pressed.
- **Per-channel debounce.** Each channel holds `stable` and a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`.
  - If the synced level equals `stable`, `cnt` clears to 0.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, `stable` takes the synced level and `cnt` clears. In all other cases `cnt` increments.
  - Any bounce back to the `stable` level restarts the count.
- **Press event.** A press is a registered 0→1 transition of `stable`, one cycle wide. Release events are ignored.
- **Pending register** (7 bits, one-hot or zero), on a press event:
  - A press on the channel already in `pending` clears `pending` to 0 (toggle off).
  - A press on any other channel loads `pending` with that channel's one-hot code.
  - For simultaneous presses in one cycle, the lowest index wins (`sw_key1` highest priority) and the others are discarded.
- **Commit FSM.** Two states, IDLE and BUSY, driven by the synced `cs_n`.
  - IDLE (synced `cs_n`=1): if `pending != flags`, then `flags <= pending` and `sel_change` pulses in the same cycle.
  - IDLE→BUSY when synced `cs_n`=0. BUSY holds `flags` unconditionally; `pending` may still change.
  - BUSY→IDLE when synced `cs_n`=1. A differing `pending` commits on the first IDLE cycle.
  - Only the final `pending` value at commit time matters. Intermediate values are never output.
- **Reset values.** Asynchronous `rst` forces the following; reset mid-frame or mid-debounce simply discards all state.
  - `flags`=0, `pending`=0, `sel_change`=0, FSM=IDLE.
  - All `cnt`=0, all `stable`=released, synchronisers to the released or idle level (`cs_n` sync=1).

## Timing
- The raw edge is sampled at edge 0. Synced level appears after edge 2. `stable` flips at edge 2+`DEBOUNCE_CYCLES`, the press event is registered at edge 3+D, and `pending` updates at edge 4+D.
- With the bus idle, `flags` and `sel_change` update at edge 5+D, i.e. D+5 cycles after the raw edge.
- `cs_n` rising to commit takes 3 cycles: 2 sync cycles plus 1 commit cycle.
- A `cs_n` fall is seen after 2 cycles. A commit can still occur within that window; the MCU must guard frames by at least 3 clocks after changing a switch. This is an accepted limitation.
- `sel_change` is exactly 1 cycle wide and is never asserted during BUSY.

## Structure
- **Package `spi_sel_pkg`:** `N_CH=7`, the default `DEBOUNCE_CYCLES`, FSM state enum (IDLE, BUSY), and the one-hot select constants `SEL_NONE`, `SEL_1`..`SEL_7`.
- **Sub-module `sw_debounce`:** one channel containing the 2-FF sync, polarity normalisation, counter, `stable`, and press-event register. Instantiated 7 times.
- **Top level:** `cs_n` sync, priority/toggle logic, `pending`, commit FSM, and flag outputs.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `SW_ACTIVE_LOW`=1.
- **Clean press:** `cs_n`=1, `sw_key3` driven low and held → `sw_flag3`=1, others 0, `sel_change` pulses once at cycle 9 (D+5) after the raw edge.
- **Bounce:** `sw_key5` toggles low/high every 2 cycles for 20 cycles, then held high → flags unchanged, no `sel_change`.
- **Mid-frame change:** selection is `SEL_2`, `cs_n`=0, then press `sw_key6` → flags stay `SEL_2`. `cs_n` rises → `SEL_6` appears and `sel_change` pulses 3 cycles after the `cs_n` edge.
- **Simultaneous press:** `sw_key4` and `sw_key7` asserted on the same cycle → `sw_flag4`=1 only.
- **Toggle off:** selection is `SEL_1`, press `sw_key1` again → all flags 0 and `sel_change` pulses.
- **Reset mid-operation:** assert `rst` mid-frame with `SEL_3` set and a debounce count in progress → all outputs 0 immediately (asynchronous). After release, a key must re-qualify the full D cycles.
